// File: rtl/conv_sequencer_if.sv
// Window/result handshake between the sequencer (master) and the convolution datapath (slave).
interface conv_sequencer_if #(
   parameter int K_DIM   = 3,
   parameter int OUT_DIM = 4
);
   localparam int RCW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

   logic                     win_valid;
   logic                     win_ready;
   logic [K_DIM*K_DIM-1:0]   win_data;
   logic [RCW-1:0]           win_row;
   logic [RCW-1:0]           win_col;
   logic                     res_valid;
   logic                     res_bit;

   modport master (
      output win_valid, win_data, win_row, win_col,
      input  win_ready, res_valid, res_bit
   );

   modport slave (
      input  win_valid, win_data, win_row, win_col,
      output win_ready, res_valid, res_bit
   );
endinterface

// File: rtl/conv_sequencer.sv
// Frame capture and raster window scan controller in front of the convolution datapath.
// Rows are latched on strobe edges; a start edge walks every KxK window and collects one bit per window.
module conv_sequencer #(
   parameter int  IMG_DIM = 6,
   parameter int  K_DIM   = 3,
   localparam int OUT_DIM = IMG_DIM - K_DIM + 1,
   localparam int RLW     = $clog2(IMG_DIM + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic [IMG_DIM-1:0]         row_data,
   input  logic                       row_strobe,
   input  logic                       start,
   conv_sequencer_if.master           win,
   output logic [OUT_DIM*OUT_DIM-1:0] out_map,
   output logic                       out_valid,
   output logic                       done,
   output logic                       busy,
   output logic [RLW-1:0]             rows_loaded
);
   localparam int RCW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int IW  = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_RUN, S_WAIT, S_DONE} state_t;

   state_t state, next;

   logic [IMG_DIM-1:0][IMG_DIM-1:0] img;
   logic [RCW-1:0]                  r_q, c_q;
   logic                            strobe_q, start_q;
   logic                            strobe_edge, start_edge;
   logic                            load_row, new_frame, scan_start, store, finish;
   logic                            last_win;
   logic [OUT_DIM*OUT_DIM-1:0]      hit;

   assign strobe_edge = row_strobe & ~strobe_q;
   assign start_edge  = start & ~start_q;
   assign last_win    = (r_q == RCW'(OUT_DIM-1)) && (c_q == RCW'(OUT_DIM-1));

   // Valid is gated by ena so the datapath never sees a transfer the sequencer cannot record.
   assign win.win_valid = (state == S_RUN) && ena;
   assign win.win_row   = r_q;
   assign win.win_col   = c_q;
   assign busy          = (state == S_RUN) || (state == S_WAIT);

   for (genvar k = 0; k < K_DIM; k++) begin : g_win
      logic [IW-1:0]      ri;
      logic [IMG_DIM-1:0] sh;
      assign ri = IW'(r_q) + IW'(k);
      assign sh = img[ri] >> c_q;
      assign win.win_data[k*K_DIM +: K_DIM] = sh[K_DIM-1:0];
   end

   for (genvar gr = 0; gr < OUT_DIM; gr++) begin : g_hr
      for (genvar gc = 0; gc < OUT_DIM; gc++) begin : g_hc
         assign hit[gr*OUT_DIM+gc] = (r_q == RCW'(gr)) && (c_q == RCW'(gc));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state <= S_IDLE;
      else if (ena) state <= next;
   end

   always_comb begin
      next       = state;
      load_row   = 1'b0;
      new_frame  = 1'b0;
      scan_start = 1'b0;
      store      = 1'b0;
      finish     = 1'b0;
      case (state)
         S_IDLE, S_LOAD: begin
            if (strobe_edge) begin
               load_row = 1'b1;
               next     = (rows_loaded == RLW'(IMG_DIM-1)) ? S_READY : S_LOAD;
            end
         end
         S_READY: begin
            if (start_edge) begin
               scan_start = 1'b1;
               next       = S_RUN;
            end
         end
         S_RUN: begin
            if (win.win_ready) next = S_WAIT;
         end
         S_WAIT: begin
            if (win.res_valid) begin
               store  = 1'b1;
               finish = last_win;
               next   = last_win ? S_DONE : S_RUN;
            end
         end
         S_DONE: begin
            // A new frame takes priority over a rescan when both edges coincide.
            if (strobe_edge) begin
               new_frame = 1'b1;
               next      = (IMG_DIM == 1) ? S_READY : S_LOAD;
            end else if (start_edge) begin
               scan_start = 1'b1;
               next       = S_RUN;
            end
         end
         default: next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_q    <= 1'b0;
         start_q     <= 1'b0;
         img         <= '0;
         rows_loaded <= '0;
         r_q         <= '0;
         c_q         <= '0;
         out_map     <= '0;
         out_valid   <= 1'b0;
         done        <= 1'b0;
      end else if (ena) begin
         strobe_q <= row_strobe;
         start_q  <= start;
         done     <= finish;
         if (new_frame) begin
            img         <= '0;
            img[0]      <= row_data;
            rows_loaded <= RLW'(1);
            out_valid   <= 1'b0;
         end else if (load_row) begin
            img[rows_loaded] <= row_data;
            rows_loaded      <= rows_loaded + RLW'(1);
         end
         if (scan_start) begin
            r_q       <= '0;
            c_q       <= '0;
            out_map   <= '0;
            out_valid <= 1'b0;
         end
         if (store) begin
            out_map <= win.res_bit ? (out_map | hit) : (out_map & ~hit);
            if (finish) begin
               out_valid <= 1'b1;
            end else if (c_q == RCW'(OUT_DIM-1)) begin
               c_q <= '0;
               r_q <= r_q + RCW'(1);
            end else begin
               c_q <= c_q + RCW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: load, scan, backpressure, early/late start, reload, reset.
module tb_conv_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, ena, row_strobe, start;
   logic [5:0]  row_data;
   logic [15:0] out_map;
   logic        out_valid, done, busy;
   logic [2:0]  rows_loaded;
   int          checks = 0;
   int          errors = 0;
   logic [5:0]  rows_tb [6];

   conv_sequencer_if #(.K_DIM(3), .OUT_DIM(4)) wif ();

   conv_sequencer #(.IMG_DIM(6), .K_DIM(3)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .row_data(row_data), .row_strobe(row_strobe),
      .start(start), .win(wif.master), .out_map(out_map), .out_valid(out_valid), .done(done),
      .busy(busy), .rows_loaded(rows_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] exp_win(input int r, input int c);
      logic [8:0] w;
      logic [5:0] rw;
      w = '0;
      for (int k = 0; k < 3; k++) begin
         rw = rows_tb[r+k];
         for (int j = 0; j < 3; j++) w[k*3+j] = rw[c+j];
      end
      return w;
   endfunction

   task automatic strobe_row(input logic [5:0] d, input int exp_cnt);
      row_data   = d;
      row_strobe = 1'b1;
      tick();
      chk("rows_loaded", 32'(rows_loaded), 32'(exp_cnt));
      row_strobe = 1'b0;
      tick();
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!wif.win_valid && n < 20) begin
         tick();
         n++;
      end
      chk("win_valid_timeout", 32'(wif.win_valid), 32'd1);
   endtask

   task automatic start_scan();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_valid", 32'(wif.win_valid), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic do_scan(input logic [15:0] rmap, input int bp_idx, input int start_idx);
      int r, c;
      for (int idx = 0; idx < 16; idx++) begin
         r = idx / 4;
         c = idx % 4;
         wait_valid();
         chk("win_row", 32'(wif.win_row), 32'(r));
         chk("win_col", 32'(wif.win_col), 32'(c));
         chk("win_data", 32'(wif.win_data), 32'(exp_win(r, c)));
         chk("done_mid", 32'(done), 32'd0);
         if (idx == 0) chk("out_map_clr", 32'(out_map), 32'd0);
         if (idx == start_idx) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("run_start_row", 32'(wif.win_row), 32'(r));
            chk("run_start_col", 32'(wif.win_col), 32'(c));
         end
         if (idx == bp_idx) begin
            for (int b = 0; b < 4; b++) begin
               tick();
               chk("bp_valid", 32'(wif.win_valid), 32'd1);
               chk("bp_data", 32'(wif.win_data), 32'(exp_win(r, c)));
               chk("bp_rowcol", {wif.win_row, wif.win_col}, {r[1:0], c[1:0]});
            end
         end
         wif.win_ready = 1'b1;
         tick();
         wif.win_ready = 1'b0;
         chk("wait_valid_low", 32'(wif.win_valid), 32'd0);
         wif.res_valid = 1'b1;
         wif.res_bit   = rmap[idx];
         tick();
         wif.res_valid = 1'b0;
         wif.res_bit   = 1'b0;
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("out_valid_set", 32'(out_valid), 32'd1);
      chk("out_map", 32'(out_map), 32'(rmap));
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("out_valid_held", 32'(out_valid), 32'd1);
      chk("busy_done", 32'(busy), 32'd0);
      chk("out_map_held", 32'(out_map), 32'(rmap));
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; row_strobe = 1'b0; start = 1'b0; row_data = '0;
      wif.win_ready = 1'b0; wif.res_valid = 1'b0; wif.res_bit = 1'b0;
      rows_tb = '{6'h3F, 6'h21, 6'h2D, 6'h2D, 6'h21, 6'h3F};
      repeat (3) tick();
      chk("rst_valid", 32'(wif.win_valid), 32'd0);
      chk("rst_rows", 32'(rows_loaded), 32'd0);
      chk("rst_outs", {out_valid, done, busy, out_map}, 32'd0);
      chk("rst_win", {wif.win_data, wif.win_row, wif.win_col}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Level held high five cycles must register once.
      row_data = 6'h3F; row_strobe = 1'b1;
      repeat (5) tick();
      chk("hold_once", 32'(rows_loaded), 32'd1);
      row_strobe = 1'b0;
      tick();
      strobe_row(6'h21, 2);
      strobe_row(6'h2D, 3);

      ena = 1'b0; row_data = 6'h00; row_strobe = 1'b1;
      repeat (2) tick();
      row_strobe = 1'b0;
      tick();
      ena = 1'b1;
      tick();
      chk("ena_frozen", 32'(rows_loaded), 32'd3);

      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("early_start_valid", 32'(wif.win_valid), 32'd0);
      chk("early_start_busy", 32'(busy), 32'd0);

      strobe_row(6'h2D, 4);
      strobe_row(6'h21, 5);
      strobe_row(6'h3F, 6);
      strobe_row(6'h15, 6);
      chk("ready_idle", {28'd0, busy, wif.win_valid, out_valid, done}, 32'd0);

      start_scan();
      chk("win00_const", 32'(wif.win_data), 32'h14F);
      do_scan(16'h0040, 5, 9);

      start_scan();
      do_scan(16'hA5C3, -1, -1);

      // Strobe and start on the same cycle in DONE: new frame wins.
      row_data = 6'h12; row_strobe = 1'b1; start = 1'b1;
      tick();
      row_strobe = 1'b0; start = 1'b0;
      chk("reload_rows", 32'(rows_loaded), 32'd1);
      chk("reload_out_valid", 32'(out_valid), 32'd0);
      chk("reload_busy", 32'(busy), 32'd0);
      repeat (3) tick();
      chk("reload_no_win", 32'(wif.win_valid), 32'd0);

      rows_tb = '{6'h12, 6'h1E, 6'h33, 6'h0C, 6'h2A, 6'h07};
      strobe_row(6'h1E, 2);
      strobe_row(6'h33, 3);
      strobe_row(6'h0C, 4);
      strobe_row(6'h2A, 5);
      strobe_row(6'h07, 6);

      start_scan();
      chk("new_win00", 32'(wif.win_data), 32'(exp_win(0, 0)));
      wif.win_ready = 1'b1;
      tick();
      wif.win_ready = 1'b0;
      wif.res_valid = 1'b1; wif.res_bit = 1'b1;
      tick();
      wif.res_valid = 1'b0; wif.res_bit = 1'b0;
      chk("mid_scan_valid", 32'(wif.win_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(wif.win_valid), 32'd0);
      chk("async_rows", 32'(rows_loaded), 32'd0);
      chk("async_outs", {out_valid, done, busy, out_map}, 32'd0);
      chk("async_win", {wif.win_data, wif.win_row, wif.win_col}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_idle", {busy, wif.win_valid, rows_loaded}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
